// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - ping-pong frame assembler and replay sequencer feeding a 4-point FFT
//
// Collects DW-bit samples into 4-sample frames across two banks. Each
// complete frame is replayed one sample per clock, and the FFT stage strobes
// are generated alongside it.
//
// Optional feature macro: FFT_SEQ_BITREV_EN
//   defined   : replay in bit-reversed order (x0, x2, x1, x3)
//   undefined : replay in natural order (x0, x1, x2, x3)
//
// Parameters:
//   DW  - sample width (two's complement)
//   GAP - idle output cycles between frames (0 = back-to-back)
//
// Ports:
//   clk         - system clock, rising edge
//   clear       - synchronous active-low reset
//   in_data     - input sample
//   in_valid    - in_data valid
//   in_ready    - sample accepted this cycle when in_valid is high
//   a           - registered sample to the FFT
//   sel         - registered FFT first-stage select
//   sel_1       - FFT second-stage select (sel delayed two clocks)
//   out_valid   - a carries a frame sample
//   frame_start - high with the first sample of each frame
module fft_frame_sequencer #(
  parameter int DW  = 4,
  parameter int GAP = 0
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] a,
  output logic          sel,
  output logic          sel_1,
  output logic          out_valid,
  output logic          frame_start
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  // The IDLE detect cycle is itself one idle output cycle, so the GAP state
  // only has to cover GAP-1 cycles to give exactly GAP idle cycles.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 1) ? (GAP - 2) : 0);

  logic [DW-1:0] mem [0:1][0:3];
  logic [1:0]    full;
  logic          wr_bank;
  logic [1:0]    wr_idx;
  logic          wr_fire;

  state_t        state, state_nxt;
  logic          rd_bank;
  logic [1:0]    rd_cnt;
  logic [1:0]    rd_idx;
  logic          rd_release;
  logic [GW-1:0] gap_cnt;

  logic [DW-1:0] a_nxt;
  logic          ov_nxt, fs_nxt, sel_nxt;
  logic          sel_d;

  assign in_ready   = !full[wr_bank];
  assign wr_fire    = in_valid && in_ready;
  assign rd_release = (state == S_STREAM) && (rd_cnt == 2'd3);

  // Write side: bank bookkeeping. A bank written and a bank released at the
  // same edge are always different banks, since writes need an empty bank.
  always_ff @(posedge clk) begin
    if (!clear) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= 2'd0;
    end else begin
      if (wr_fire) begin
        wr_idx <= wr_idx + 2'd1;
        if (wr_idx == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_release) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Sample storage needs no reset; the full flags say what is meaningful.
  always_ff @(posedge clk) begin
    if (clear && wr_fire) begin
      mem[wr_bank][wr_idx] <= in_data;
    end
  end

  // Read FSM: state register.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read counters. rd_cnt sits at 0 outside STREAM so every frame starts at 0.
  always_ff @(posedge clk) begin
    if (!clear) begin
      rd_cnt  <= 2'd0;
      rd_bank <= 1'b0;
      gap_cnt <= '0;
    end else begin
      rd_cnt  <= (state == S_STREAM) ? rd_cnt + 2'd1 : 2'd0;
      rd_bank <= rd_bank ^ rd_release;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Read FSM: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (rd_cnt == 2'd3) begin
          if (GAP > 1)                 state_nxt = S_GAP;
          else if (GAP == 1)           state_nxt = S_IDLE;
          else if (full[~rd_bank])     state_nxt = S_STREAM;
          else                         state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read FSM: output values, registered below.
  always_comb begin
`ifdef FFT_SEQ_BITREV_EN
    rd_idx = {rd_cnt[0], rd_cnt[1]};
`else
    rd_idx = rd_cnt;
`endif
    a_nxt   = '0;
    ov_nxt  = 1'b0;
    fs_nxt  = 1'b0;
    sel_nxt = 1'b0;
    if (state == S_STREAM) begin
      a_nxt   = mem[rd_bank][rd_idx];
      ov_nxt  = 1'b1;
      fs_nxt  = (rd_cnt == 2'd0);
      sel_nxt = rd_cnt[1];
    end
  end

  // Output registers; sel_1 trails sel by two clocks and keeps running after
  // out_valid falls so the FFT can drain its second stage.
  always_ff @(posedge clk) begin
    if (!clear) begin
      a           <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sel         <= 1'b0;
      sel_d       <= 1'b0;
      sel_1       <= 1'b0;
    end else begin
      a           <= a_nxt;
      out_valid   <= ov_nxt;
      frame_start <= fs_nxt;
      sel         <= sel_nxt;
      sel_d       <= sel;
      sel_1       <= sel_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - self-checking bench for fft_frame_sequencer (GAP=0 and GAP=4 instances)
module tb_fft_frame_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] in_data;
  logic       in_valid;
  int         target;
  int         cyc = 0;

  int compared   = 0;
  int mismatched = 0;
  int stalls     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v0, v1;
  logic       r0, r1, s0, s1, sl0, sl1, ov0, ov1, fs0, fs1;
  logic [3:0] a0, a1;

  assign v0 = in_valid && (target == 0);
  assign v1 = in_valid && (target == 1);

  fft_frame_sequencer #(.DW(4), .GAP(0)) dut0 (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(v0), .in_ready(r0),
    .a(a0), .sel(s0), .sel_1(sl0), .out_valid(ov0), .frame_start(fs0)
  );

  fft_frame_sequencer #(.DW(4), .GAP(4)) dut1 (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(v1), .in_ready(r1),
    .a(a1), .sel(s1), .sel_1(sl1), .out_valid(ov1), .frame_start(fs1)
  );

  // Reference model state, one slot per instance.
  logic [3:0] expq [2][$];
  logic [3:0] part [2][$];
  int         fs_cyc [2][$];
  int         end_cyc [2][$];
  int         buffered [2];
  int         pos [2];
  logic       selh1 [2];
  logic       selh2 [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int ord(input int k);
`ifdef FFT_SEQ_BITREV_EN
    return ((k & 1) << 1) | (k >> 1);
`else
    return k;
`endif
  endfunction

  // Frame-level model: a frame is queued for replay when its 4th sample is
  // accepted; a bank counts as occupied until its last sample appears.
  task automatic mon(input int d, input logic rdy, input logic ov, input logic fs,
                     input logic sl, input logic sl_1, input logic [3:0] av, input logic vin);
    logic       exp_sel;
    logic [3:0] e;
    exp_sel = 1'b0;
    if (ov) begin
      if (expq[d].size() == 0) begin
        chk($sformatf("spurious_valid%0d", d), {31'b0, ov}, 32'd0);
      end else begin
        e = expq[d].pop_front();
        chk($sformatf("a%0d", d), {28'b0, av}, {28'b0, e});
        chk($sformatf("frame_start%0d", d), {31'b0, fs}, {31'b0, pos[d] == 0});
        exp_sel = (pos[d] >= 2);
        chk($sformatf("sel%0d", d), {31'b0, sl}, {31'b0, exp_sel});
        if (pos[d] == 0) fs_cyc[d].push_back(cyc);
        if (pos[d] == 3) begin
          end_cyc[d].push_back(cyc);
          buffered[d]--;
        end
        pos[d] = (pos[d] + 1) % 4;
      end
    end else begin
      chk($sformatf("idle_a%0d", d), {28'b0, av}, 32'd0);
      chk($sformatf("idle_fs%0d", d), {31'b0, fs}, 32'd0);
      chk($sformatf("idle_sel%0d", d), {31'b0, sl}, 32'd0);
    end
    chk($sformatf("sel_1_%0d", d), {31'b0, sl_1}, {31'b0, selh2[d]});
    selh2[d] = selh1[d];
    selh1[d] = exp_sel;
    chk($sformatf("in_ready%0d", d), {31'b0, rdy}, {31'b0, buffered[d] < 2});
    if (!clear) begin
      expq[d].delete();
      part[d].delete();
      buffered[d] = 0;
      pos[d]      = 0;
      selh1[d]    = 1'b0;
      selh2[d]    = 1'b0;
    end else if (vin && rdy) begin
      part[d].push_back(in_data);
      if (part[d].size() == 4) begin
        for (int k = 0; k < 4; k++) expq[d].push_back(part[d][ord(k)]);
        part[d].delete();
        buffered[d]++;
      end
    end
  endtask

  always @(negedge clk) mon(0, r0, ov0, fs0, s0, sl0, a0, v0);
  always @(negedge clk) mon(1, r1, ov1, fs1, s1, sl1, a1, v1);

  function automatic logic cur_rdy();
    return (target == 0) ? r0 : r1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b1;
  endtask

  task automatic push(input logic [3:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!cur_rdy() && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("push_timeout", n, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq[target].size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) chk("drain_timeout", n, 32'd0);
    tick(4);
  endtask

  // Directed single frame on dut0: latency, values and strobes over 6 cycles.
  task automatic frame_check(input logic [3:0] x0, x1, x2, x3, input int e0, e1, e2, e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    push(x0); push(x1); push(x2); push(x3);
    @(negedge clk);
    chk("latency_e0", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    chk("latency_e1", {31'b0, ov0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("frm_ov[%0d]", i), {31'b0, ov0}, {31'b0, i < 4});
      chk($sformatf("frm_a[%0d]", i), {28'b0, a0}, (i < 4) ? e[i] : 0);
      chk($sformatf("frm_fs[%0d]", i), {31'b0, fs0}, {31'b0, i == 0});
      chk($sformatf("frm_sel[%0d]", i), {31'b0, s0}, {31'b0, i == 2 || i == 3});
      chk($sformatf("frm_sel_1[%0d]", i), {31'b0, sl0}, {31'b0, i == 4 || i == 5});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nf;
    for (int d = 0; d < 2; d++) begin
      buffered[d] = 0; pos[d] = 0; selh1[d] = 1'b0; selh2[d] = 1'b0;
    end
    clear = 1'b0; in_valid = 1'b0; in_data = 4'd0; target = 0;
    tick(2);
    clear = 1'b1;
    @(negedge clk);
    chk("rst_a", {28'b0, a0}, 32'd0);
    chk("rst_ov", {31'b0, ov0}, 32'd0);
    chk("rst_sel", {31'b0, s0}, 32'd0);
    chk("rst_sel_1", {31'b0, sl0}, 32'd0);
    chk("rst_fs", {31'b0, fs0}, 32'd0);
    chk("rst_ready0", {31'b0, r0}, 32'd1);
    chk("rst_ready1", {31'b0, r1}, 32'd1);
    @(posedge clk);
    #1;

    // Single frames.
`ifdef FFT_SEQ_BITREV_EN
    frame_check(4'd5, 4'd3, 4'd2, 4'd7, 5, 2, 3, 7);
    frame_check(4'd1, 4'd2, 4'd3, 4'd4, 1, 3, 2, 4);
`else
    frame_check(4'd5, 4'd3, 4'd2, 4'd7, 5, 3, 2, 7);
    frame_check(4'd1, 4'd2, 4'd3, 4'd4, 1, 2, 3, 4);
`endif
    tick(3);

    // Back-to-back frames.
    do_reset();
    stalls = 0;
    nf = fs_cyc[0].size();
    push(4'd5); push(4'd3); push(4'd2); push(4'd7);
    push(4'd3); push(4'hF); push(4'd2); push(4'hF);
    chk("b2b_stalls", stalls, 32'd0);
    drain();
    chk("b2b_frames", fs_cyc[0].size() - nf, 32'd2);
    if (fs_cyc[0].size() >= nf + 2 && end_cyc[0].size() >= nf + 2) begin
      chk("b2b_start_spacing", fs_cyc[0][nf+1] - fs_cyc[0][nf], 32'd4);
      chk("b2b_contiguous", end_cyc[0][nf+1] - fs_cyc[0][nf], 32'd7);
    end

    // Backpressure on the GAP=4 instance.
    target = 1;
    do_reset();
    stalls = 0;
    nf = fs_cyc[1].size();
    for (int i = 0; i < 12; i++) push(4'($urandom));
    chk("bp_stalled", {31'b0, stalls > 0}, 32'd1);
    drain();
    chk("bp_frames", fs_cyc[1].size() - nf, 32'd3);
    if (fs_cyc[1].size() >= nf + 3) begin
      for (int i = 1; i < 3; i++)
        chk($sformatf("bp_gap[%0d]", i), fs_cyc[1][nf+i] - end_cyc[1][nf+i-1] - 1, 32'd4);
    end
    target = 0;

    // Reset with a partial frame pending.
    do_reset();
    nf = fs_cyc[0].size();
    push(4'd5); push(4'd3);
    do_reset();
    @(negedge clk);
    chk("rstmid_ov", {31'b0, ov0}, 32'd0);
    chk("rstmid_a", {28'b0, a0}, 32'd0);
    chk("rstmid_ready", {31'b0, r0}, 32'd1);
    @(posedge clk);
    #1;
    push(4'd2); push(4'd7); push(4'd1); push(4'd4);
    drain();
    chk("rstmid_frames", fs_cyc[0].size() - nf, 32'd1);

    // Reset while a frame is streaming.
    push(4'd9); push(4'd8); push(4'd7); push(4'd6);
    tick(3);
    do_reset();
    @(negedge clk);
    chk("rststream_ov", {31'b0, ov0}, 32'd0);
    chk("rststream_a", {28'b0, a0}, 32'd0);
    chk("rststream_sel", {31'b0, s0}, 32'd0);
    chk("rststream_fs", {31'b0, fs0}, 32'd0);
    @(posedge clk);
    #1;
    nf = fs_cyc[0].size();
    tick(10);
    chk("rststream_quiet", fs_cyc[0].size() - nf, 32'd0);

    // Idle input: three samples produce nothing until the fourth arrives.
    push(4'd3); push(4'd6); push(4'd12);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_wait[%0d]", i), {31'b0, ov0}, 32'd0);
    end
    @(posedge clk);
    #1;
    push(4'd1);
    @(negedge clk);
    chk("idle_lat0", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    chk("idle_lat1", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    chk("idle_lat2", {31'b0, ov0}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic on the GAP=0 instance.
    do_reset();
    nf = fs_cyc[0].size();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom);
      tick(1);
    end
    in_valid = 1'b0;
    drain();
    chk("rand_some_frames", {31'b0, fs_cyc[0].size() - nf > 10}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
